max19506_serial_rx: RTL and testbench
=====================================

// Module: max19506_serial_rx
// PURPOSE
//  Responder (peripheral) side of the MAX19506 3-wire serial control link. It
//  oversamples SCLK/SDIN/SPEN on clk and decodes 16-bit frames into a shadow
//  register file. It sits in the ADC model/loopback path and consumes frames
//  from the serial-interface initiator.
//  - Frame = 16 bits, MSB first: bit15 R/W (0=write, 1=read), bits14:8 address,
//    bits7:0 data.
// PARAMETERS
//  NUM_REGS     8     number of 8-bit shadow registers; addresses 0..NUM_REGS-1
//  SYNC_STAGES  2     synchroniser depth on sclk/sdin/spen (2..4)
// PORTS
//  clk          in   1            system clock; must be >= 4x SCLK frequency
//  reset        in   1            synchronous, active-high
//  sclk         in   1            serial clock, async to clk; idles low
//  sdin         in   1            serial data; sampled on SCLK rising edge
//  spen         in   1            frame enable, active-low
//  sdout        out  1            readback data (READBACK_EN only, else 0)
//  sdout_oe     out  1            readback output enable (READBACK_EN only, else 0)
//  regs         out  NUM_REGS*8   shadow regs, flattened, reg0 at [7:0]
//  wr_valid     out  1            1-cycle pulse when a register is written
//  wr_addr      out  7            address of the last write (held)
//  wr_data      out  8            data of the last write (held)
//  frame_err    out  1            1-cycle pulse on an aborted or bad-address frame
//  shdn         out  1            regs[0] bit 0 (power-down request)
// BEHAVIOUR
//  - Reset: all outputs 0, regs 0, FSM = IDLE, bit count 0.
//    sclk/sdin/spen pass through SYNC_STAGES flops; edges are detected on the
//    last stage versus a delayed copy.
//  - FSM IDLE: on a spen falling edge -> SHIFT; clear the shift register and
//    the 5-bit bit count.
//  - FSM SHIFT: on each sclk rising edge, shift sdin into the LSB and
//    increment the count. When the count reaches 16 -> COMMIT on the next cycle.
//  - FSM COMMIT (1 cycle), write frame:
//    - addr < NUM_REGS: regs[addr] <= data; wr_valid=1; wr_addr/wr_data
//      updated in the same cycle.
//    - addr >= NUM_REGS: no write; frame_err=1.
//  - FSM COMMIT, read frame: no register change and no pulse.
//  - COMMIT then -> DONE.
//  - FSM DONE: ignore further sclk edges; on spen rising edge -> IDLE.
//  - spen rising edge in SHIFT with count < 16: abort, frame_err=1, no write,
//    -> IDLE.
//  - spen rising edge and 16th sclk rising edge detected in the same clk
//    cycle: the sclk edge is processed first, so the frame completes via
//    COMMIT (no error), then -> IDLE.
//  - Latency: wr_valid asserts SYNC_STAGES+2 clk cycles after the 16th sclk
//    rising edge at the pins.
//  - Reset asserted mid-frame: immediate return to IDLE and regs cleared. The
//    rest of the current spen-low window is ignored until spen goes high.
//  - A second frame inside one spen-low window is not supported. DONE absorbs it.
// CONFIGURATION
//  MAX19506_SERIAL_RX_READBACK_EN
//  - Defined: for a read frame (bit15=1) with addr < NUM_REGS:
//    - sdout_oe=1 from the clk after the 8th sclk rising edge until spen rises
//      or the frame reaches DONE.
//    - regs[addr] drives sdout MSB first, changing after each sclk falling edge.
//    - Read with addr >= NUM_REGS: sdout_oe stays 0 and frame_err pulses in
//      COMMIT.
//  - Undefined: sdout=0, sdout_oe=0; read frames are decoded and ignored.
// TESTING
//  1. Write 0x0301 (addr 3, data 0x01), SCLK = clk/8 -> one wr_valid pulse,
//     wr_addr=3, wr_data=0x01, regs[31:24]=0x01.
//  2. Write 0x0001 -> shdn=1; then write 0x0000 -> shdn=0; frame_err stays 0.
//  3. spen low, 9 sclk edges, spen high -> frame_err pulse, wr_valid=0,
//     regs unchanged.
//  4. Write 0x0A55 with NUM_REGS=8 -> frame_err pulse, no write.
//  5. Write 0x02AA, reset asserted after 10 bits, then a full write 0x0212 ->
//     regs[2]=0x12, no error.
//  6. READBACK_EN: write 0x02C3, then read 0x8200 -> sdout shifts 1,1,0,0,0,0,1,1
//     on bits 7..0.

Source files
------------

// File: rtl/max19506_serial_rx.sv
// max19506_serial_rx
// Responder side of the MAX19506 3-wire serial control link. SCLK, SDIN and
// SPEN are oversampled on clk, 16-bit frames (R/W, 7-bit address, 8-bit data,
// MSB first) are decoded, and write frames update a shadow register file.
// Optional feature macro: MAX19506_SERIAL_RX_READBACK_EN enables driving
// register contents back on sdout for read frames.
module max19506_serial_rx #(
   parameter int NUM_REGS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  sdin,
   input  logic                  spen,
   output logic                  sdout,
   output logic                  sdout_oe,
   output logic [NUM_REGS*8-1:0] regs,
   output logic                  wr_valid,
   output logic [6:0]            wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_err,
   output logic                  shdn
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, spen_sync_q;
   logic                   sclk_dly_q, spen_dly_q;
   logic                   sclk_s, sdin_s, spen_s;
   logic                   sclk_rise, spen_rise, spen_fall;

   logic [1:0]  state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:0]  regs_q [NUM_REGS];
   logic [7:0]  regs_d [NUM_REGS];
   logic        wr_valid_q, wr_valid_d;
   logic [6:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        frame_err_q, frame_err_d;

   logic [6:0]  frm_addr;
   logic        frm_addr_ok;

   // Synchronise the async serial pins and keep a delayed copy for edge detection.
   // Resetting to 0 means a low SPEN during reset never looks like a falling edge,
   // so the remainder of an interrupted frame is ignored until SPEN goes high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         sdin_sync_q <= '0;
         spen_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         spen_dly_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin};
         spen_sync_q <= {spen_sync_q[SYNC_STAGES-2:0], spen};
         sclk_dly_q  <= sclk_s;
         spen_dly_q  <= spen_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
   assign spen_s    = spen_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign spen_rise = spen_s & ~spen_dly_q;
   assign spen_fall = ~spen_s & spen_dly_q;

   assign frm_addr    = shift_q[14:8];
   assign frm_addr_ok = ({1'b0, frm_addr} < NUM_REGS_L);

   // Frame FSM: collect 16 bits, then commit writes or flag bad/aborted frames.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      regs_d      = regs_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (spen_fall) begin
               state_d = ST_SHIFT;
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               shift_d = {shift_q[14:0], sdin_s};
               cnt_d   = cnt_q + 5'd1;
            end
            // A 16th edge coinciding with SPEN rising still completes the frame.
            if (sclk_rise && cnt_q == 5'd15) begin
               state_d = ST_COMMIT;
            end else if (spen_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
            end
         end
         ST_COMMIT: begin
            state_d = ST_DONE;
            if (!shift_q[15]) begin
               if (frm_addr_ok) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (frm_addr == 7'(i)) regs_d[i] = shift_q[7:0];
                  end
                  wr_valid_d = 1'b1;
                  wr_addr_d  = frm_addr;
                  wr_data_d  = shift_q[7:0];
               end else begin
                  frame_err_d = 1'b1;
               end
            end
`ifdef MAX19506_SERIAL_RX_READBACK_EN
            else if (!frm_addr_ok) begin
               frame_err_d = 1'b1;
            end
`endif
         end
         default: begin
            // DONE: swallow any further SCLK activity until the window closes.
            if (spen_s) state_d = ST_IDLE;
         end
      endcase
   end

   // Frame state and register file; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
         regs_q      <= regs_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
      assign regs[g*8 +: 8] = regs_q[g];
   end

   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign frame_err = frame_err_q;
   assign shdn      = regs_q[0][0];

`ifdef MAX19506_SERIAL_RX_READBACK_EN
   logic       sclk_fall;
   logic       oe_q, oe_d;
   logic       sdout_q, sdout_d;
   logic [7:0] rd_sr_q, rd_sr_d;
   logic [6:0] rd_addr;
   logic [7:0] rd_sel;

   assign sclk_fall = ~sclk_s & sclk_dly_q;
   // Address as it stands once the 8th bit is being shifted in.
   assign rd_addr   = {shift_q[5:0], sdin_s};

   // Readback shifter: load on the 8th edge of a valid read, shift out on falling edges.
   always_comb begin
      oe_d    = oe_q;
      sdout_d = sdout_q;
      rd_sr_d = rd_sr_q;
      rd_sel  = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == 7'(i)) rd_sel = regs_q[i];
      end
      if (state_q == ST_SHIFT && sclk_rise && cnt_q == 5'd7 && shift_q[6] &&
          ({1'b0, rd_addr} < NUM_REGS_L)) begin
         oe_d    = 1'b1;
         rd_sr_d = rd_sel;
      end
      if (oe_q && sclk_fall) begin
         sdout_d = rd_sr_q[7];
         rd_sr_d = {rd_sr_q[6:0], 1'b0};
      end
      if (state_q != ST_SHIFT || spen_rise) begin
         oe_d    = 1'b0;
         sdout_d = 1'b0;
      end
   end

   // Readback output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         oe_q    <= 1'b0;
         sdout_q <= 1'b0;
         rd_sr_q <= '0;
      end else begin
         oe_q    <= oe_d;
         sdout_q <= sdout_d;
         rd_sr_q <= rd_sr_d;
      end
   end

   assign sdout    = sdout_q;
   assign sdout_oe = oe_q;
`else
   assign sdout    = 1'b0;
   assign sdout_oe = 1'b0;
`endif

endmodule

// File: tb/tb_max19506_serial_rx.sv
// tb_max19506_serial_rx
// Drives serial frames (SCLK = clk/8) into max19506_serial_rx and compares the
// register file, write/error pulses and readback against a frame-level model.
module tb_max19506_serial_rx;
   localparam int NUM_REGS    = 8;
   localparam int SYNC_STAGES = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  sclk = 1'b0;
   logic                  sdin = 1'b0;
   logic                  spen = 1'b1;
   logic                  sdout, sdout_oe, wr_valid, frame_err, shdn;
   logic [NUM_REGS*8-1:0] regs;
   logic [6:0]            wr_addr;
   logic [7:0]            wr_data;

   max19506_serial_rx #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .spen(spen),
      .sdout(sdout), .sdout_oe(sdout_oe), .regs(regs), .wr_valid(wr_valid),
      .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err), .shdn(shdn)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0, err_cnt = 0;
   bit oe_seen = 1'b0, sd_seen = 1'b0;

   logic [7:0] mdl [NUM_REGS];
   int         exp_wr = 0, exp_err = 0;
   logic [6:0] exp_waddr = '0;
   logic [7:0] exp_wdata = '0;
   logic [7:0] rd_byte;
   bit         oe_ok;
   int         frame_no = 0;

`ifdef MAX19506_SERIAL_RX_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   // Observe output pulses away from the active edge.
   always @(negedge clk) begin
      if (wr_valid)  wr_cnt++;
      if (frame_err) err_cnt++;
      if (sdout_oe)  oe_seen = 1'b1;
      if (sdout)     sd_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mdl_flat();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) v[i*8 +: 8] = mdl[i];
      return v;
   endfunction

   // Drive one spen-low window: nbits SCLK pulses, optional SPEN rise on the
   // last rising edge, optional reset in the middle of the window.
   task automatic send(input logic [15:0] f, input int nbits, input bit spen_last, input bit rst_mid);
      spen = 1'b0;
      clks(4);
      rd_byte = '0;
      oe_ok   = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         sdin = f[15-i];
         clks(4);
         if (i >= 8) begin
            rd_byte = {rd_byte[6:0], sdout};
            if (!sdout_oe) oe_ok = 1'b0;
         end
         sclk = 1'b1;
         if (spen_last && i == nbits - 1) spen = 1'b1;
         clks(4);
         sclk = 1'b0;
      end
      if (rst_mid) begin
         reset = 1'b1;
         clks(2);
         reset = 1'b0;
         repeat (3) begin
            sdin = 1'($urandom);
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
         end
      end
      clks(4);
      spen = 1'b1;
      clks(10);
   endtask

   // Frame-level reference: decide the outcome from the frame fields, drive it, compare.
   task automatic run(input logic [15:0] f, input int nbits, input bit spen_last, input bit rst_mid);
      int         a;
      bit         rd_valid;
      logic [7:0] exp_rd;
      a        = int'(f[14:8]);
      rd_valid = RB && f[15] && (a < NUM_REGS) && nbits >= 8;
      exp_rd   = (a < NUM_REGS) ? mdl[a] : 8'h00;
      if (rst_mid) begin
         for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
         exp_waddr = '0;
         exp_wdata = '0;
      end else if (nbits < 16) begin
         exp_err++;
      end else if (!f[15]) begin
         if (a < NUM_REGS) begin
            mdl[a]    = f[7:0];
            exp_wr++;
            exp_waddr = f[14:8];
            exp_wdata = f[7:0];
         end else begin
            exp_err++;
         end
      end else if (RB && a >= NUM_REGS) begin
         exp_err++;
      end
      oe_seen = 1'b0;
      sd_seen = 1'b0;
      send(f, nbits, spen_last, rst_mid);
      frame_no++;
      chk($sformatf("f%0d_%04h wr_pulses", frame_no, f), 64'(wr_cnt), 64'(exp_wr));
      chk($sformatf("f%0d_%04h err_pulses", frame_no, f), 64'(err_cnt), 64'(exp_err));
      chk($sformatf("f%0d_%04h regs", frame_no, f), regs, mdl_flat());
      chk($sformatf("f%0d_%04h wr_addr", frame_no, f), 64'(wr_addr), 64'(exp_waddr));
      chk($sformatf("f%0d_%04h wr_data", frame_no, f), 64'(wr_data), 64'(exp_wdata));
      chk($sformatf("f%0d_%04h shdn", frame_no, f), 64'(shdn), 64'(mdl[0][0]));
      if (rd_valid) begin
         if (nbits == 16 && !rst_mid) begin
            chk($sformatf("f%0d_%04h rd_byte", frame_no, f), 64'(rd_byte), 64'(exp_rd));
            chk($sformatf("f%0d_%04h rd_oe", frame_no, f), 64'(oe_ok), 64'd1);
         end
      end else begin
         chk($sformatf("f%0d_%04h oe_idle", frame_no, f), 64'(oe_seen), 64'd0);
         chk($sformatf("f%0d_%04h sdout_idle", frame_no, f), 64'(sd_seen), 64'd0);
      end
   endtask

   initial begin
      logic [15:0] f;
      int          nb;
      bit          sl;
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
      clks(5);
      reset = 1'b0;
      clks(2);
      chk("rst regs", regs, 64'd0);
      chk("rst wr_valid", 64'(wr_valid), 64'd0);
      chk("rst frame_err", 64'(frame_err), 64'd0);
      chk("rst wr_addr", 64'(wr_addr), 64'd0);
      chk("rst wr_data", 64'(wr_data), 64'd0);
      chk("rst sdout_oe", 64'(sdout_oe), 64'd0);
      chk("rst shdn", 64'(shdn), 64'd0);
      wr_cnt  = 0;
      err_cnt = 0;

      run(16'h0301, 16, 1'b0, 1'b0);   // basic write
      run(16'h0001, 16, 1'b0, 1'b0);   // shdn on
      run(16'h0000, 16, 1'b0, 1'b0);   // shdn off
      run(16'h0455, 9,  1'b0, 1'b0);   // aborted after 9 bits
      run(16'h0A55, 16, 1'b0, 1'b0);   // address out of range
      run(16'h02AA, 10, 1'b0, 1'b1);   // reset mid-frame
      run(16'h0212, 16, 1'b0, 1'b0);   // full write after reset
      run(16'h0777, 16, 1'b1, 1'b0);   // SPEN rises with the 16th edge
      run(16'h7F00, 16, 1'b0, 1'b0);   // highest address
      run(16'h02C3, 16, 1'b0, 1'b0);
      run(16'h8200, 16, 1'b0, 1'b0);   // read back reg 2
      run(16'h8B00, 16, 1'b0, 1'b0);   // read out of range
      run(16'h0515, 1,  1'b0, 1'b0);   // single-bit abort

      for (int n = 0; n < 30; n++) begin
         f[15]   = ($urandom_range(0, 3) == 0);
         f[14:8] = 7'($urandom_range(0, 11));
         f[7:0]  = 8'($urandom);
         nb      = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16;
         sl      = (nb == 16) && ($urandom_range(0, 5) == 0);
         run(f, nb, sl, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
